// File: rtl/dmni_multi_rx.sv
`default_nettype none
// ============================================================================
// Module   : dmni_multi_rx
// Purpose  : Multi-channel DMNI receive front-end. Each Hermes input link
//            has its own credit-based flit FIFO and end-of-packet timestamp
//            FIFO. Whole packets are granted round-robin onto a single
//            DMA-side stream, tagged with source channel and receive tick.
// Revision : 1.0 - initial release
// ============================================================================
module dmni_multi_rx #(
  parameter int N_CHANNELS  = 4,
  parameter int FLIT_SIZE   = 32,
  parameter int BUFFER_SIZE = 16,
  parameter int TS_DEPTH    = 4,
  localparam int CH_W       = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [31:0]                     tick_counter_i,
  input  logic [N_CHANNELS-1:0]           noc_rx_i,
  input  logic [N_CHANNELS-1:0]           noc_eop_i,
  input  logic [N_CHANNELS*FLIT_SIZE-1:0] noc_data_i,
  output logic [N_CHANNELS-1:0]           noc_credit_o,
  output logic                            tx_o,
  input  logic                            tx_ack_i,
  output logic [FLIT_SIZE-1:0]            data_o,
  output logic                            eop_o,
  output logic [CH_W-1:0]                 ch_o,
  output logic [31:0]                     rcv_timestamp_o,
  output logic                            busy_o,
  output logic [N_CHANNELS-1:0]           pending_o
);

  localparam int FA_W = $clog2(BUFFER_SIZE);
  localparam int FC_W = FA_W + 1;
  localparam int TA_W = $clog2(TS_DEPTH);
  localparam int TC_W = TA_W + 1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic [0:0]            state, state_nxt;
  logic [CH_W-1:0]       grant, grant_nxt;
  logic [CH_W-1:0]       rr_ptr, rr_nxt;
  logic [CH_W-1:0]       pick;
  logic                  found;
  logic [CH_W-1:0]       cand [N_CHANNELS];
  logic                  xfer;

  logic [N_CHANNELS-1:0] flit_empty;
  logic [N_CHANNELS-1:0] flit_full;
  logic [N_CHANNELS-1:0] ts_full;
  logic [N_CHANNELS-1:0] push;
  logic [N_CHANNELS-1:0] ts_push;
  logic [N_CHANNELS-1:0] flit_pop;
  logic [N_CHANNELS-1:0] ts_pop;
  logic [FLIT_SIZE:0]    flit_head [N_CHANNELS];
  logic [31:0]           ts_head   [N_CHANNELS];

  // A transfer happens only on the granted channel; tx_o never looks at tx_ack_i.
  assign xfer = tx_o && tx_ack_i;

  for (genvar k = 0; k < N_CHANNELS; k++) begin : g_ch
    logic [FLIT_SIZE:0] fmem [BUFFER_SIZE];
    logic [FA_W-1:0]    f_wr, f_rd;
    logic [FC_W-1:0]    f_cnt;
    logic [31:0]        tmem [TS_DEPTH];
    logic [TA_W-1:0]    t_wr, t_rd;
    logic [TC_W-1:0]    t_cnt;

    assign flit_empty[k] = (f_cnt == '0);
    assign flit_full[k]  = (f_cnt == FC_W'(BUFFER_SIZE));
    assign ts_full[k]    = (t_cnt == TC_W'(TS_DEPTH));
    // Credit comes from registered counts only, so a same-cycle pop never frees a slot.
    assign noc_credit_o[k] = !rst_i && !flit_full[k] && !ts_full[k];
    assign push[k]       = noc_rx_i[k] && noc_credit_o[k];
    assign ts_push[k]    = push[k] && noc_eop_i[k];
    assign flit_pop[k]   = xfer && (grant == CH_W'(k));
    // The timestamp leaves together with its eop flit.
    assign ts_pop[k]     = flit_pop[k] && flit_head[k][FLIT_SIZE];
    assign flit_head[k]  = fmem[f_rd];
    assign ts_head[k]    = tmem[t_rd];

    // Storage write: {eop,data} per flit, tick per eop flit.
    always_ff @(posedge clk_i) begin
      if (push[k]) begin
        fmem[f_wr] <= {noc_eop_i[k], noc_data_i[k*FLIT_SIZE +: FLIT_SIZE]};
      end
      if (ts_push[k]) begin
        tmem[t_wr] <= tick_counter_i;
      end
    end

    // Pointer and occupancy bookkeeping for both FIFOs of this channel.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        f_wr  <= '0;
        f_rd  <= '0;
        f_cnt <= '0;
        t_wr  <= '0;
        t_rd  <= '0;
        t_cnt <= '0;
      end else begin
        if (push[k])     f_wr <= f_wr + FA_W'(1);
        if (flit_pop[k]) f_rd <= f_rd + FA_W'(1);
        case ({push[k], flit_pop[k]})
          2'b10:   f_cnt <= f_cnt + FC_W'(1);
          2'b01:   f_cnt <= f_cnt - FC_W'(1);
          default: f_cnt <= f_cnt;
        endcase
        if (ts_push[k]) t_wr <= t_wr + TA_W'(1);
        if (ts_pop[k])  t_rd <= t_rd + TA_W'(1);
        case ({ts_push[k], ts_pop[k]})
          2'b10:   t_cnt <= t_cnt + TC_W'(1);
          2'b01:   t_cnt <= t_cnt - TC_W'(1);
          default: t_cnt <= t_cnt;
        endcase
      end
    end
  end

  // Round-robin search: first non-empty channel at or after rr_ptr.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      cand[i] = CH_W'((int'(rr_ptr) + i) % N_CHANNELS);
      if (!found && !flit_empty[cand[i]]) begin
        found = 1'b1;
        pick  = cand[i];
      end
    end
  end

  // FSM state, grant and round-robin pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= S_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  // Next state: lock on a packet in IDLE, release after its eop flit leaves.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_nxt    = rr_ptr;
    case (state)
      S_IDLE: begin
        if (found) begin
          grant_nxt = pick;
          state_nxt = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (xfer && flit_head[grant][FLIT_SIZE]) begin
          state_nxt = S_IDLE;
          rr_nxt    = (grant == CH_W'(N_CHANNELS - 1)) ? '0 : grant + CH_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs: stream comes from the head of the granted channel's FIFOs.
  always_comb begin
    busy_o          = (state == S_LOCKED);
    tx_o            = (state == S_LOCKED) && !flit_empty[grant];
    ch_o            = grant;
    data_o          = flit_head[grant][FLIT_SIZE-1:0];
    eop_o           = tx_o && flit_head[grant][FLIT_SIZE];
    rcv_timestamp_o = ts_head[grant];
    pending_o       = ~flit_empty;
  end

endmodule
`default_nettype wire

// File: doc/dmni_multi_rx.md
Name: dmni_multi_rx

Overview:
- Multi-channel receive front-end for the DMNI.
- Takes N_CHANNELS independent Hermes input links. Each link gets its own credit-based flit buffer and an end-of-packet timestamp queue.
- Arbitrates whole packets round-robin onto a single DMA-side stream.
- Replaces the single-link receive buffer and timestamp pair. Each delivered packet carries its source channel index and a receive tick stamp.

Parameters:
- N_CHANNELS, 4, number of Hermes input links (1..8)
- FLIT_SIZE, 32, Hermes flit width in bits
- BUFFER_SIZE, 16, flit FIFO depth per channel; power of two, >= 2
- TS_DEPTH, 4, timestamp FIFO depth per channel; power of two, >= 2
- CH_W, max(1,$clog2(N_CHANNELS)), channel index width (derived, localparam)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- tick_counter_i  in  32  free-running tick count
- noc_rx_i  in  N_CHANNELS  per-channel flit valid
- noc_eop_i  in  N_CHANNELS  per-channel end-of-packet flag
- noc_data_i  in  N_CHANNELS*FLIT_SIZE  per-channel flit; channel k at bits [k*FLIT_SIZE +: FLIT_SIZE]
- noc_credit_o  out  N_CHANNELS  per-channel ready
- tx_o  out  1  output flit valid
- tx_ack_i  in  1  output flit accepted
- data_o  out  FLIT_SIZE  output flit
- eop_o  out  1  output flit is last of packet
- ch_o  out  CH_W  source channel of current packet
- rcv_timestamp_o  out  32  tick at which the eop flit entered the block; valid when tx_o && eop_o
- busy_o  out  1  packet grant held
- pending_o  out  N_CHANNELS  channel has at least one buffered flit

Behaviour:
- Clocking and reset:
  - Single clock clk_i; reset rst_i is synchronous and active-high.
  - Reset clears all FIFO pointers and counts, FSM to IDLE, round-robin pointer to 0.
  - Reset outputs: noc_credit_o=0 while rst_i is high, all-ones the cycle after reset releases; tx_o=0, eop_o=0, busy_o=0, ch_o=0, pending_o=0.
  - data_o and rcv_timestamp_o are don't-care while tx_o=0.
- Input side, per channel k:
  - noc_credit_o[k] = !flit_full[k] && !ts_full[k], computed from registered counts.
  - A push in the same cycle as a pop does not make room; a full FIFO refuses that cycle.
  - A flit is accepted when noc_rx_i[k] && noc_credit_o[k]; {eop,data} is written into the flit FIFO.
  - If the accepted flit has eop=1, tick_counter_i of that cycle is written into the ts FIFO the same cycle.
  - Simultaneous push and pop on one FIFO is legal; the count is unchanged.
- FSM states: IDLE, LOCKED.
- IDLE:
  - Among channels with a non-empty flit FIFO, select the first at or after rr_ptr (rr_ptr, rr_ptr+1, ... modulo N_CHANNELS).
  - Register the selection as grant, set ch_o=grant and busy_o=1, go to LOCKED.
  - tx_o=0 in IDLE, so there is one cycle of arbitration bubble per packet.
  - If no channel is non-empty, stay in IDLE.
- LOCKED:
  - tx_o = flit FIFO[grant] non-empty; data_o and eop_o come from that FIFO's head.
  - rcv_timestamp_o = head of ts FIFO[grant]. It is guaranteed present when the eop flit is at the head, since it was pushed the same cycle the eop flit was.
  - A flit is transferred on tx_o && tx_ack_i, which pops flit FIFO[grant].
  - On transfer of an eop flit:
    - also pop ts FIFO[grant];
    - set rr_ptr = grant+1 (wrap to 0 at N_CHANNELS);
    - go to IDLE and deassert busy_o next cycle.
  - While locked, other channels keep filling but are not served: no interleaving within a packet.
  - An underflowing grant channel (empty mid-packet) holds tx_o=0 and stays LOCKED.
- tx_o must not depend combinationally on tx_ack_i.
- pending_o[k] = flit FIFO[k] non-empty.
- N_CHANNELS=1: arbiter degenerates; ch_o=0; the IDLE bubble still applies.
- Reset mid-packet drops all buffered flits and timestamps. No partial packet is emitted after reset.
- Pointers wrap modulo depth. Full and empty are distinguished with an extra count or pointer bit.

Test Plan:
- Single packet: ch2 sends flits A,B,C with eop on C at tick 100, tx_ack_i=1 -> output A,B,C; ch_o=2; eop_o on C; rcv_timestamp_o=100; busy_o falls after C.
- Round-robin: ch0 and ch1 each hold 2 single-flit packets before the first grant -> delivery order ch0,ch1,ch0,ch1; one IDLE bubble between packets.
- No interleave: ch3 is mid-packet (2 of 4 flits sent) when ch0 becomes non-empty -> ch3's remaining 2 flits go out before any ch0 flit.
- Backpressure/full: tx_ack_i=0, ch1 sends 20 flits, BUFFER_SIZE=16 -> noc_credit_o[1] drops after 16 accepted flits. Releasing tx_ack_i gives 16 outputs in order, and credit returns the cycle after the first pop.
- Timestamp FIFO full: ch0 sends 5 single-flit packets with TS_DEPTH=4 and tx_ack_i=0 -> credit drops after the 4th. The released stream carries 4 distinct ticks in order.
- Reset mid-packet: assert rst_i while ch1 is LOCKED with 3 flits buffered -> next cycle tx_o=0, busy_o=0, pending_o=0. A new ch0 packet afterwards is delivered with ch_o=0.
